// File: rtl/if_fetch_unit.sv
// if_fetch_unit: program counter, instruction-memory fetch handshake, one-entry stall skid and branch redirect/flush.
// Ports: clk/rst (async active-high); stall, branch_taken, branch_target from decode/execute;
// imem_req/imem_addr out and imem_ready/imem_rdata back from instruction memory;
// inst_valid/inst_out/inst_mem_addr carry the fetched instruction and its address to decode/execute.
module if_fetch_unit #(
  parameter int ADDR_W = 11,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] inst_mem_addr
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;
  state_t state;
  logic [ADDR_W-1:0] pc, skid_addr, tgt, pc_inc;
  logic [31:0] skid_data;
  logic pending;
  assign tgt = branch_target & ~ADDR_W'(3);
  assign pc_inc = pc + ADDR_W'(4);
  assign pending = (state == REQ || state == DRAIN) && !imem_ready;
  // imem_req/imem_addr are registered so stall and branch_taken never reach memory combinationally.
  // A redirect with a fetch still outstanding keeps the old address on the bus until memory answers.
  // The skid has no valid bit: it is only ever read in HOLD, where it is always full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      inst_valid <= 1'b0;
      inst_out <= NOP_INST;
      inst_mem_addr <= '0;
      skid_data <= NOP_INST;
      skid_addr <= '0;
    end else if (branch_taken) begin
      pc <= tgt;
      inst_valid <= 1'b0;
      inst_out <= NOP_INST;
      imem_req <= 1'b1;
      state <= pending ? DRAIN : REQ;
      if (!pending) imem_addr <= tgt;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          imem_req <= 1'b1;
          imem_addr <= pc;
        end
        REQ: begin
          if (imem_ready) begin
            pc <= pc_inc;
            imem_addr <= pc_inc;
            if (stall) begin
              skid_data <= imem_rdata;
              skid_addr <= pc;
              imem_req <= 1'b0;
              state <= HOLD;
            end else begin
              inst_out <= imem_rdata;
              inst_mem_addr <= pc;
              inst_valid <= 1'b1;
            end
          end else if (!stall) begin
            inst_valid <= 1'b0;
            inst_out <= NOP_INST;
          end
        end
        HOLD: begin
          if (!stall) begin
            inst_out <= skid_data;
            inst_mem_addr <= skid_addr;
            inst_valid <= 1'b1;
            imem_req <= 1'b1;
            imem_addr <= pc;
            state <= REQ;
          end
        end
        DRAIN: begin
          if (imem_ready) begin
            imem_addr <= pc;
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios plus randomized stream checked against a program-order reference model.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0, rst = 1, stall = 0, branch_taken = 0, imem_ready = 0;
  logic [10:0] branch_target = '0;
  logic imem_req, inst_valid, imem_req2, inst_valid2;
  logic [10:0] imem_addr, inst_mem_addr, imem_addr2, inst_mem_addr2;
  logic [31:0] imem_rdata, inst_out, imem_rdata2, inst_out2;
  int checks = 0, failures = 0;

  function automatic logic [31:0] mem_word(input logic [10:0] a);
    return {10'h2A5, ~a, a};
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign imem_rdata2 = mem_word(imem_addr2);

  always #5 clk = ~clk;

  if_fetch_unit dut (.clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_out(inst_out), .inst_mem_addr(inst_mem_addr));

  if_fetch_unit #(.RESET_PC(11'h7F8)) dut2 (.clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .imem_req(imem_req2),
    .imem_addr(imem_addr2), .imem_ready(imem_ready), .imem_rdata(imem_rdata2),
    .inst_valid(inst_valid2), .inst_out(inst_out2), .inst_mem_addr(inst_mem_addr2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    stall = 0;
    branch_taken = 0;
    tick();
    rst = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    chk("reset_req", {31'd0, imem_req}, 0);
    chk("reset_addr", {21'd0, imem_addr}, 0);
    chk("reset_valid", {31'd0, inst_valid}, 0);
    chk("reset_inst", inst_out, NOP);
    chk("reset_memaddr", {21'd0, inst_mem_addr}, 0);
    chk("reset_addr2", {21'd0, imem_addr2}, 32'h7F8);
  endtask

  task automatic test_zero_wait();
    logic [10:0] e, e2;
    imem_ready = 1;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin
        chk("zw_first_req", {31'd0, imem_req}, 1);
        chk("zw_first_addr", {21'd0, imem_addr}, 0);
        chk("zw_first_valid", {31'd0, inst_valid}, 0);
      end else begin
        e = 11'(4 * (k - 2));
        e2 = 11'h7F8 + 11'(4 * (k - 2));
        chk("zw_valid", {31'd0, inst_valid}, 1);
        chk("zw_memaddr", {21'd0, inst_mem_addr}, {21'd0, e});
        chk("zw_inst", inst_out, mem_word(e));
        chk("wrap_memaddr", {21'd0, inst_mem_addr2}, {21'd0, e2});
        chk("wrap_inst", inst_out2, mem_word(e2));
      end
    end
  endtask

  task automatic test_wait_states();
    imem_ready = 0;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("ws_req", {31'd0, imem_req}, 1);
      chk("ws_addr", {21'd0, imem_addr}, 0);
      chk("ws_valid", {31'd0, inst_valid}, 0);
      chk("ws_inst", inst_out, NOP);
    end
    imem_ready = 1;
    tick();
    chk("ws_resp_valid", {31'd0, inst_valid}, 1);
    chk("ws_resp_memaddr", {21'd0, inst_mem_addr}, 0);
    chk("ws_resp_inst", inst_out, mem_word(11'h000));
  endtask

  task automatic test_stall();
    imem_ready = 1;
    do_reset();
    for (int k = 1; k <= 4; k++) tick();
    chk("st_pre_memaddr", {21'd0, inst_mem_addr}, 8);
    chk("st_pre_addr", {21'd0, imem_addr}, 32'h00C);
    stall = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("st_hold_valid", {31'd0, inst_valid}, 1);
      chk("st_hold_memaddr", {21'd0, inst_mem_addr}, 8);
      chk("st_hold_inst", inst_out, mem_word(11'h008));
      chk("st_hold_req", {31'd0, imem_req}, 0);
    end
    stall = 0;
    tick();
    chk("st_rel_memaddr", {21'd0, inst_mem_addr}, 32'h00C);
    chk("st_rel_inst", inst_out, mem_word(11'h00C));
    chk("st_rel_addr", {21'd0, imem_addr}, 32'h010);
    tick();
    chk("st_next_memaddr", {21'd0, inst_mem_addr}, 32'h010);
    chk("st_next_valid", {31'd0, inst_valid}, 1);
  endtask

  task automatic test_branch_drain();
    int n = 0;
    imem_ready = 1;
    do_reset();
    while (imem_addr !== 11'h020 && n < 50) begin
      tick();
      n++;
    end
    chk("br_reach_020", {21'd0, imem_addr}, 32'h020);
    imem_ready = 0;
    tick();
    branch_taken = 1;
    branch_target = 11'h103;
    tick();
    branch_taken = 0;
    chk("br_valid_drop", {31'd0, inst_valid}, 0);
    chk("br_inst_nop", inst_out, NOP);
    chk("br_drain_addr", {21'd0, imem_addr}, 32'h020);
    chk("br_drain_req", {31'd0, imem_req}, 1);
    tick();
    chk("br_drain_addr2", {21'd0, imem_addr}, 32'h020);
    imem_ready = 1;
    tick();
    chk("br_post_addr", {21'd0, imem_addr}, 32'h100);
    chk("br_discard_valid", {31'd0, inst_valid}, 0);
    tick();
    chk("br_tgt_valid", {31'd0, inst_valid}, 1);
    chk("br_tgt_memaddr", {21'd0, inst_mem_addr}, 32'h100);
    chk("br_tgt_inst", inst_out, mem_word(11'h100));
  endtask

  task automatic test_branch_stall_hold();
    imem_ready = 1;
    do_reset();
    for (int k = 1; k <= 3; k++) tick();
    stall = 1;
    tick();
    chk("bs_hold_req", {31'd0, imem_req}, 0);
    chk("bs_hold_memaddr", {21'd0, inst_mem_addr}, 4);
    branch_taken = 1;
    branch_target = 11'h2A6;
    tick();
    branch_taken = 0;
    stall = 0;
    chk("bs_req", {31'd0, imem_req}, 1);
    chk("bs_addr", {21'd0, imem_addr}, 32'h2A4);
    chk("bs_valid", {31'd0, inst_valid}, 0);
    tick();
    chk("bs_tgt_memaddr", {21'd0, inst_mem_addr}, 32'h2A4);
    chk("bs_tgt_valid", {31'd0, inst_valid}, 1);
  endtask

  task automatic test_async_reset();
    imem_ready = 1;
    do_reset();
    for (int k = 1; k <= 3; k++) tick();
    #2;
    rst = 1;
    #1;
    chk("ar_req", {31'd0, imem_req}, 0);
    chk("ar_addr", {21'd0, imem_addr}, 0);
    chk("ar_valid", {31'd0, inst_valid}, 0);
    chk("ar_inst", inst_out, NOP);
    chk("ar_memaddr", {21'd0, inst_mem_addr}, 0);
    chk("ar_addr2", {21'd0, imem_addr2}, 32'h7F8);
    tick();
    rst = 0;
  endtask

  // Reference: instructions leave fetch in program order from the reset PC, +4 each,
  // restarting at the aligned target on a branch. One is consumed whenever it is shown
  // valid with no stall and no branch that cycle.
  task automatic test_random();
    logic [10:0] exp, prev_addr;
    logic prev_pending;
    int consumed = 0;
    imem_ready = 0;
    do_reset();
    exp = 11'h000;
    prev_pending = 0;
    prev_addr = '0;
    for (int c = 0; c < 800; c++) begin
      if (prev_pending) begin
        chk("rnd_req_stable", {31'd0, imem_req}, 1);
        chk("rnd_addr_stable", {21'd0, imem_addr}, {21'd0, prev_addr});
      end
      chk("rnd_align", {30'd0, imem_addr[1:0]}, 0);
      if (inst_valid) chk("rnd_inst", inst_out, mem_word(inst_mem_addr));
      else chk("rnd_nop", inst_out, NOP);
      stall = ($urandom % 4) == 0;
      imem_ready = ($urandom % 2) == 0;
      branch_taken = ($urandom % 20) == 0;
      branch_target = 11'($urandom);
      if (branch_taken) exp = branch_target & ~11'd3;
      else if (inst_valid && !stall) begin
        chk("rnd_order", {21'd0, inst_mem_addr}, {21'd0, exp});
        exp = exp + 11'd4;
        consumed++;
      end
      prev_pending = imem_req && !imem_ready;
      prev_addr = imem_addr;
      tick();
    end
    branch_taken = 0;
    stall = 0;
    chk("rnd_progress", {31'd0, consumed > 100}, 1);
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_branch_drain();
    test_branch_stall_hold();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch unit and producer of the PC/instruction pair consumed by the execute stage.
- Owns the program counter and issues word fetches to instruction memory over a req/ready handshake.
- Presents each fetched instruction with its 11-bit address (inst_mem_addr), which feeds the execute-stage rs1/PC operand mux.
- Handles pipeline stall (one-entry skid buffer) and branch redirect/flush from execute.

Parameters:
ADDR_W, 11, instruction-memory byte address width
RESET_PC, 0, PC value loaded on reset
NOP_INST, 32'h00000013, instruction driven on inst_out while invalid/flushed (addi x0,x0,0)

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  decode/execute cannot accept a new instruction this cycle
branch_taken  input  1  redirect request from execute, single-cycle pulse
branch_target  input  ADDR_W  redirect byte address
imem_req  output  1  fetch request valid
imem_addr  output  ADDR_W  fetch byte address, word aligned
imem_ready  input  1  memory response valid for the current request; may be asserted in the same cycle as imem_req
imem_rdata  input  32  instruction word, valid when imem_ready=1
inst_valid  output  1  inst_out/inst_mem_addr hold a live instruction
inst_out  output  32  instruction to decode
inst_mem_addr  output  ADDR_W  address of inst_out, to execute operand mux

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_out=NOP_INST, inst_mem_addr=0, skid empty. Reset mid-request abandons the request; memory must tolerate this.
- PC arithmetic:
  - pc+4 is modulo 2^ADDR_W (0x7FC -> 0x000).
  - branch_target[1:0] is forced to 00.
  - imem_addr is always word aligned.
- States IDLE, REQ, HOLD, DRAIN:
  - IDLE: entered only from reset. On the next clock -> REQ.
  - REQ: imem_req=1, imem_addr=pc. Address stays stable until imem_ready.
    - imem_ready & !stall: inst_out<=imem_rdata, inst_mem_addr<=pc, inst_valid<=1, pc<=pc+4, remain REQ. Zero-wait memory gives 1 instruction/cycle.
    - imem_ready & stall: capture {imem_rdata, pc} into skid, pc<=pc+4, -> HOLD. Output register unchanged.
    - !imem_ready & !stall: inst_valid<=0, inst_out<=NOP_INST.
    - !imem_ready & stall: outputs held.
  - HOLD: imem_req=0. When stall=0, move skid to output (inst_valid<=1), clear skid, -> REQ.
  - DRAIN: imem_req=1 with the old address. On imem_ready, discard data -> REQ (pc already holds the target).
- branch_taken has priority over stall and over every other event in the same cycle:
  - pc<=target, inst_valid<=0, inst_out<=NOP_INST, skid cleared.
  - From REQ with !imem_ready: -> DRAIN.
  - From REQ with imem_ready: data discarded -> REQ.
  - From HOLD or DRAIN: -> REQ (from DRAIN only if imem_ready; otherwise stay DRAIN with the new target).
  - From IDLE: -> REQ with the target.
- Stall with inst_valid=1 holds inst_out, inst_mem_addr and inst_valid unchanged.
- Latency: with zero-wait memory, first inst_valid=1 on the 2nd rising edge after rst deasserts. N wait cycles add N.
- No combinational path from stall or branch_taken to imem_req/imem_addr. Both are registered from state/pc.

Test Plan:
- Reset then zero-wait memory (imem_ready tied 1, rdata=addr-derived): inst_mem_addr sequence 0x000, 0x004, 0x008 on consecutive cycles, inst_valid=1 from 2nd edge, inst_out matches each address.
- Wait states: imem_ready asserted 3 cycles after req. imem_addr stays 0x000 throughout, inst_valid=0 and inst_out=0x00000013 until the response, then inst_mem_addr=0x000.
- Stall for 4 cycles during streaming:
  - Outputs frozen at 0x008, one fetch of 0x00C captured in skid, imem_req=0 in HOLD.
  - After release, 0x00C then 0x010 with no loss or duplication.
- Branch to 0x103 while a 0x020 fetch is pending:
  - inst_valid drops next cycle, DRAIN completes 0x020 and discards it.
  - Next fetch address 0x100, then inst_mem_addr=0x100.
- Branch and stall asserted together in HOLD: skid discarded, next fetch at target, branch wins.
- RESET_PC=0x7F8, zero-wait: addresses 0x7F8, 0x7FC, 0x000 (wrap). rst asserted mid-request: outputs return to reset values immediately, asynchronously.
